register_dump_controller: RTL and testbench

Sequencer that freezes the pipeline and streams the full 32-entry general-purpose register file out over a byte-wide valid/ready link for the debug unit. It drives the instruction-decode stage's debug read-address port and captures the returned register word. It then serialises each word as four bytes, MSB first, toward the UART transmitter. It owns the halt request/acknowledge handshake with the pipeline control so register contents are stable for the whole dump.

---
 rtl/register_dump_controller.sv | 182 ++++++++++++++++++
 tb/tb_register_dump_controller.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/register_dump_controller.sv
// Freezes the pipeline and streams the 32-entry register file out MSB-first over a byte-wide valid/ready link.
// Optional: define REG_DUMP_CHECKSUM_EN to append a running-XOR checksum byte after the last register.
module register_dump_controller #(
  parameter int NB_DATA        = 32,
  parameter int NB_REG_ADDRESS = 5,
  parameter int NB_BYTE        = 8,
  parameter int N_REGISTERS    = 32
) (
  input  logic                      i_clock,
  input  logic                      i_reset,
  input  logic                      i_start,
  output logic                      o_halt_request,
  input  logic                      i_halt_ack,
  output logic [NB_REG_ADDRESS-1:0] o_debug_read_reg_address,
  input  logic [NB_DATA-1:0]        i_debug_read_reg,
  output logic [NB_BYTE-1:0]        o_tx_data,
  output logic                      o_tx_valid,
  input  logic                      i_tx_ready,
  output logic                      o_busy,
  output logic                      o_done
);

  localparam int N_BYTES = NB_DATA / NB_BYTE;
  localparam int NB_IDX  = (N_BYTES > 1) ? $clog2(N_BYTES) : 1;
  localparam logic [NB_IDX-1:0]         LAST_IDX  = NB_IDX'(N_BYTES - 1);
  localparam logic [NB_REG_ADDRESS-1:0] LAST_ADDR = NB_REG_ADDRESS'(N_REGISTERS - 1);

  // state     | meaning
  // IDLE      | waiting for i_start
  // HALT_WAIT | halt requested, waiting for i_halt_ack
  // LOAD      | capture register word at current address
  // SEND      | shift four bytes out MSB-first
  // CHECKSUM  | present the XOR checksum byte (checksum build only)
  // DONE      | one-cycle completion pulse, then release halt
  typedef enum logic [2:0] {
    S_IDLE,
    S_HALT_WAIT,
    S_LOAD,
    S_SEND,
`ifdef REG_DUMP_CHECKSUM_EN
    S_CHECKSUM,
`endif
    S_DONE
  } state_t;

  state_t                    state_q, state_d;
  logic [NB_REG_ADDRESS-1:0] addr_q, addr_d;
  logic [NB_DATA-1:0]        word_q, word_d;
  logic [NB_IDX-1:0]         idx_q, idx_d;
  logic [NB_BYTE-1:0]        tx_data_q, tx_data_d;
  logic                      tx_valid_q, tx_valid_d;
  logic                      halt_q, halt_d;
  logic                      busy_q, busy_d;
  logic                      done_q, done_d;
`ifdef REG_DUMP_CHECKSUM_EN
  logic [NB_BYTE-1:0]        chk_q, chk_d;
`endif
  logic                      xfer;

  assign xfer = tx_valid_q && i_tx_ready;

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      word_q     <= '0;
      idx_q      <= '0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
      halt_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
`ifdef REG_DUMP_CHECKSUM_EN
      chk_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      word_q     <= word_d;
      idx_q      <= idx_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      halt_q     <= halt_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
`ifdef REG_DUMP_CHECKSUM_EN
      chk_q      <= chk_d;
`endif
    end
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    word_d     = word_q;
    idx_d      = idx_q;
    tx_data_d  = tx_data_q;
    tx_valid_d = tx_valid_q;
    halt_d     = halt_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
`ifdef REG_DUMP_CHECKSUM_EN
    chk_d      = chk_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          state_d = S_HALT_WAIT;
          halt_d  = 1'b1;
          busy_d  = 1'b1;
          addr_d  = '0;
`ifdef REG_DUMP_CHECKSUM_EN
          chk_d   = '0;
`endif
        end
      end
      S_HALT_WAIT: begin
        if (i_halt_ack) state_d = S_LOAD;
      end
      S_LOAD: begin
        word_d     = i_debug_read_reg;
        tx_data_d  = i_debug_read_reg[NB_DATA-1 -: NB_BYTE];
        tx_valid_d = 1'b1;
        idx_d      = '0;
        state_d    = S_SEND;
      end
      S_SEND: begin
        if (xfer) begin
`ifdef REG_DUMP_CHECKSUM_EN
          chk_d = chk_q ^ tx_data_q;
`endif
          if (idx_q != LAST_IDX) begin
            idx_d     = idx_q + NB_IDX'(1);
            word_d    = word_q << NB_BYTE;
            tx_data_d = word_q[NB_DATA-NB_BYTE-1 -: NB_BYTE];
          end else if (addr_q != LAST_ADDR) begin
            tx_valid_d = 1'b0;
            addr_d     = addr_q + NB_REG_ADDRESS'(1);
            state_d    = S_LOAD;
          end else begin
`ifdef REG_DUMP_CHECKSUM_EN
            // Checksum goes out back-to-back so it costs a single extra cycle.
            tx_data_d  = chk_q ^ tx_data_q;
            state_d    = S_CHECKSUM;
`else
            tx_valid_d = 1'b0;
            addr_d     = '0;
            done_d     = 1'b1;
            state_d    = S_DONE;
`endif
          end
        end
      end
`ifdef REG_DUMP_CHECKSUM_EN
      S_CHECKSUM: begin
        if (xfer) begin
          tx_valid_d = 1'b0;
          addr_d     = '0;
          done_d     = 1'b1;
          state_d    = S_DONE;
        end
      end
`endif
      S_DONE: begin
        state_d = S_IDLE;
        halt_d  = 1'b0;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign o_halt_request           = halt_q;
  assign o_debug_read_reg_address = addr_q;
  assign o_tx_data                = tx_data_q;
  assign o_tx_valid               = tx_valid_q;
  assign o_busy                   = busy_q;
  assign o_done                   = done_q;

endmodule

// File: tb/tb_register_dump_controller.sv
// Directed bench for register_dump_controller; honours REG_DUMP_CHECKSUM_EN to expect the trailing checksum byte.
module tb_register_dump_controller;

  localparam int NREG = 32;
`ifdef REG_DUMP_CHECKSUM_EN
  localparam int CHK = 1;
`else
  localparam int CHK = 0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        start, ack, ready;
  logic        halt, txv, busy, done;
  logic [4:0]  addr;
  logic [31:0] rd;
  logic [7:0]  txd;
  logic [31:0] regs [NREG];

  assign rd = regs[addr];
  always #5 clk = ~clk;

  register_dump_controller dut (
    .i_clock                  (clk),
    .i_reset                  (rst),
    .i_start                  (start),
    .o_halt_request           (halt),
    .i_halt_ack               (ack),
    .o_debug_read_reg_address (addr),
    .i_debug_read_reg         (rd),
    .o_tx_data                (txd),
    .o_tx_valid               (txv),
    .i_tx_ready               (ready),
    .o_busy                   (busy),
    .o_done                   (done)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  logic [7:0] got_q [$];
  logic [7:0] exp_q [$];

  task automatic load_pattern(input int p);
    logic [7:0] x;
    for (int r = 0; r < NREG; r++) begin
      case (p)
        0:       regs[r] = 32'h0100_0000 * 32'(r) + 32'(r);
        1:       regs[r] = 32'hA5A5_A5A5;
        2:       regs[r] = (r == 1) ? 32'h0000_00FF : 32'h0;
        default: regs[r] = 32'hDEAD_BEEF ^ (32'h0103_0507 * 32'(r + 1));
      endcase
    end
    exp_q.delete();
    x = 8'h00;
    for (int r = 0; r < NREG; r++)
      for (int b = 3; b >= 0; b--) begin
        exp_q.push_back(regs[r][8*b +: 8]);
        x ^= regs[r][8*b +: 8];
      end
    if (CHK == 1) exp_q.push_back(x);
  endtask

  task automatic compare_stream(input string name);
    int mism;
    int lim;
    mism = 0;
    lim  = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    check({name, " byte count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < lim; i++)
      if (got_q[i] !== exp_q[i]) begin
        if (mism == 0)
          $display("  first differing byte %0d: got %02h expected %02h", i, got_q[i], exp_q[i]);
        mism++;
      end
    check({name, " byte errors"}, mism, 0);
  endtask

  function automatic logic ready_val(input int mode, input int n);
    case (mode)
      0:       return 1'b1;
      1:       return n[0];
      2:       return (n % 3) != 0;
      default: return ((n * 5) % 7) > 2;
    endcase
  endfunction

  int r_cycles, r_done_cnt, r_done_cycle, r_first_valid, r_early;
  int r_stalls, r_unstable, r_halt_drop, r_timeout;
  logic r_busy0, r_halt0;
  logic [4:0] r_addr0;

  task automatic run_dump(input int ack_delay, input int ready_mode, input int start_pulse_at,
                          input bit ack_pulse);
    int n;
    logic prev_stall;
    logic [7:0] prev_data;
    got_q.delete();
    r_done_cnt = 0; r_done_cycle = -1; r_first_valid = -1; r_early = 0;
    r_stalls = 0; r_unstable = 0; r_halt_drop = 0; r_timeout = 1;
    @(negedge clk);
    start = 1'b1;
    ack   = 1'b0;
    ready = ready_val(ready_mode, -1);
    @(posedge clk); #1;
    n = 0;
    r_busy0 = busy; r_halt0 = halt; r_addr0 = addr;
    prev_stall = 1'b0;
    prev_data  = 8'h00;
    while (n < 3000) begin
      start = (n == start_pulse_at);
      if (n == ack_delay) ack = 1'b1;
      else if (ack_pulse && n == ack_delay + 1) ack = 1'b0;
      ready = ready_val(ready_mode, n);
      if (done) begin r_done_cnt++; r_done_cycle = n; end
      if (n > 0 && !busy) begin r_timeout = 0; break; end
      if (!halt) r_halt_drop++;
      if (txv && r_first_valid < 0) r_first_valid = n;
      if (txv && n < ack_delay + 2) r_early++;
      if (prev_stall && (!txv || txd !== prev_data)) r_unstable++;
      @(negedge clk);
      if (txv && ready) got_q.push_back(txd);
      if (txv && !ready) r_stalls++;
      prev_stall = txv && !ready;
      prev_data  = txd;
      @(posedge clk); #1;
      n++;
    end
    r_cycles = n;
    start = 1'b0; ack = 1'b0; ready = 1'b0;
  endtask

  typedef struct {
    string name;
    int    ack_delay;
    int    ready_mode;
    int    start_pulse;
    bit    ack_pulse;
    int    pattern;
  } vec_t;

  vec_t vecs [7];

  initial begin
    vecs[0] = '{"basic",        0,  0, -1, 1'b0, 0};
    vecs[1] = '{"ack_delay10",  10, 0, -1, 1'b0, 0};
    vecs[2] = '{"ready_toggle", 0,  1, -1, 1'b0, 0};
    vecs[3] = '{"start_mid",    0,  0, 50, 1'b0, 3};
    vecs[4] = '{"ack_pulse_bp", 3,  2, -1, 1'b1, 3};
    vecs[5] = '{"all_a5",       0,  0, -1, 1'b0, 1};
    vecs[6] = '{"r1_ff",        2,  3, -1, 1'b0, 2};

    for (int r = 0; r < NREG; r++) regs[r] = 32'h0;
    rst = 1'b1; start = 1'b0; ack = 1'b0; ready = 1'b0;
    #1;
    check("reset tx_valid", txv, 0);
    check("reset halt", halt, 0);
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset addr", addr, 0);
    check("reset tx_data", txd, 0);
    #20;
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(posedge clk);

    for (int v = 0; v < 7; v++) begin
      load_pattern(vecs[v].pattern);
      run_dump(vecs[v].ack_delay, vecs[v].ready_mode, vecs[v].start_pulse, vecs[v].ack_pulse);
      check({vecs[v].name, " timeout"}, r_timeout, 0);
      check({vecs[v].name, " busy after start"}, r_busy0, 1);
      check({vecs[v].name, " halt after start"}, r_halt0, 1);
      check({vecs[v].name, " addr in halt_wait"}, r_addr0, 0);
      check({vecs[v].name, " duration"}, r_cycles, 162 + CHK + vecs[v].ack_delay + r_stalls);
      check({vecs[v].name, " done pulses"}, r_done_cnt, 1);
      check({vecs[v].name, " done cycle"}, r_done_cycle, r_cycles - 1);
      check({vecs[v].name, " first valid cycle"}, r_first_valid, vecs[v].ack_delay + 2);
      check({vecs[v].name, " valid before ack"}, r_early, 0);
      check({vecs[v].name, " halt dropped"}, r_halt_drop, 0);
      check({vecs[v].name, " data unstable"}, r_unstable, 0);
      if (vecs[v].ready_mode == 0) check({vecs[v].name, " stalls"}, r_stalls, 0);
      else check({vecs[v].name, " stalls seen"}, (r_stalls > 0) ? 1 : 0, 1);
      compare_stream(vecs[v].name);
`ifdef REG_DUMP_CHECKSUM_EN
      if (vecs[v].pattern == 1 && got_q.size() == 129) check("checksum a5", got_q[128], 8'h00);
      if (vecs[v].pattern == 2 && got_q.size() == 129) check("checksum ff", got_q[128], 8'hFF);
`endif
      repeat (3) @(posedge clk);
    end

    // Async reset while register 7 byte 2 is on the link.
    load_pattern(0);
    @(negedge clk);
    start = 1'b1; ack = 1'b1; ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (39) begin @(posedge clk); #1; end
    check("midreset addr", addr, 7);
    check("midreset valid before", txv, 1);
    check("midreset byte before", txd, regs[7][15:8]);
    #2 rst = 1'b1;
    #1;
    check("midreset tx_valid", txv, 0);
    check("midreset halt", halt, 0);
    check("midreset busy", busy, 0);
    check("midreset addr cleared", addr, 0);
    check("midreset tx_data", txd, 0);
    @(negedge clk);
    rst = 1'b0; ack = 1'b0; ready = 1'b0;
    repeat (2) @(posedge clk);
    load_pattern(3);
    run_dump(0, 0, -1, 1'b0);
    check("after reset timeout", r_timeout, 0);
    check("after reset duration", r_cycles, 162 + CHK);
    check("after reset done pulses", r_done_cnt, 1);
    compare_stream("after reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
